// File: rtl/conv_interleave_tx.sv
// conv_interleave_tx
//   Burst transmitter: latches one payload word, appends K-1 zero tail bits,
//   convolutionally encodes at rate 1/2 (generators G0/G1), writes the coded
//   bits row-major into a ROWS x COLS block interleaver, then reads them out
//   column-major as SYM_W-bit symbols under a valid/ready handshake.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_data/in_valid      payload word and its valid (in_data[0] encoded first)
//   in_ready              high only while idle
//   sym_out/sym_valid     output symbol (sym_out[SYM_W-1] is earliest bit) and valid
//   sym_ready             downstream accepts sym_out this cycle
//   burst_done            1-cycle pulse after the last symbol is accepted
module conv_interleave_tx #(
  parameter int             DATA_W = 62,
  parameter int             K      = 3,
  parameter logic [K-1:0]   G0     = 3'b111,
  parameter logic [K-1:0]   G1     = 3'b101,
  parameter int             ROWS   = 16,
  parameter int             COLS   = 8,
  parameter int             SYM_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              burst_done
);

  localparam int NBITS = DATA_W + K - 1;      // encoder input bits incl. tail
  localparam int NCODE = 2 * NBITS;           // coded bits == ROWS*COLS
  localparam int NSYM  = NCODE / SYM_W;
  localparam int BW    = $clog2(NBITS);
  localparam int SW    = $clog2(NSYM);
  localparam int KW    = $clog2(NCODE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]       state;
  logic [NBITS-1:0] data_q;   // payload plus zero tail, shifted right as consumed
  logic [K-2:0]     sr;       // {u[i-1], u[i-2]}
  logic [BW-1:0]    bit_idx;
  logic [SW-1:0]    sym_idx;
  logic [NCODE-1:0] buf_q;    // flat buffer, coded bit k at index k (row-major)
  logic [SYM_W-1:0] sym_bits;

  logic         u;
  logic [K-1:0] win;
  logic         c0, c1;

  assign u   = data_q[0];
  assign win = {u, sr};
  assign c0  = ^(G0 & win);
  assign c1  = ^(G1 & win);

  // Column-major read: stream bit j lives at row j%ROWS, col j/ROWS.
  always_comb begin
    sym_bits = '0;
    for (int b = 0; b < SYM_W; b++) begin
      int j, k;
      j = int'(sym_idx) * SYM_W + b;
      k = (j % ROWS) * COLS + (j / ROWS);
      sym_bits[SYM_W-1-b] = buf_q[KW'(k)];
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign sym_valid = (state == S_SEND);
  assign sym_out   = (state == S_SEND) ? sym_bits : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      data_q     <= '0;
      sr         <= '0;
      bit_idx    <= '0;
      sym_idx    <= '0;
      buf_q      <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q  <= {{(K-1){1'b0}}, in_data};
            sr      <= '0;
            bit_idx <= '0;
            sym_idx <= '0;
            state   <= S_ENC;
          end
        end
        S_ENC: begin
          // Coded pair for input bit i lands at k=2i and k=2i+1.
          buf_q[{bit_idx, 1'b0}] <= c0;
          buf_q[{bit_idx, 1'b1}] <= c1;
          sr     <= {u, sr[K-2:1]};
          data_q <= data_q >> 1;
          if (bit_idx == BW'(NBITS-1)) state   <= S_SEND;
          else                         bit_idx <= bit_idx + 1'b1;
        end
        S_SEND: begin
          if (sym_ready) begin
            if (sym_idx == SW'(NSYM-1)) begin
              state      <= S_IDLE;
              burst_done <= 1'b1;
            end else begin
              sym_idx <= sym_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_interleave_tx.sv
module tb_conv_interleave_tx;

  logic        clk;
  logic        reset_n;
  logic [61:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sym_out;
  logic        sym_valid;
  logic        sym_ready;
  logic        burst_done;

  conv_interleave_tx dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: encode with integer shift state, then interleave by index math.
  function automatic logic [127:0] model_stream(input logic [61:0] p);
    logic [127:0] coded, st;
    int u, p1, p2;
    p1 = 0; p2 = 0;
    for (int i = 0; i < 64; i++) begin
      u = (i < 62) ? int'(p[i]) : 0;
      coded[2*i]   = 1'(u ^ p1 ^ p2);
      coded[2*i+1] = 1'(u ^ p2);
      p2 = p1;
      p1 = u;
    end
    for (int j = 0; j < 128; j++) st[j] = coded[(j % 16) * 8 + j / 16];
    return st;
  endfunction

  // Loopback: deinterleave and invert the 5-octal branch (c1 = u ^ u[i-2]).
  function automatic logic [61:0] decode(input logic [127:0] st);
    logic [127:0] coded;
    logic [63:0]  u;
    for (int j = 0; j < 128; j++) coded[(j % 16) * 8 + j / 16] = st[j];
    for (int i = 0; i < 64; i++) u[i] = coded[2*i+1] ^ ((i >= 2) ? u[i-2] : 1'b0);
    return u[61:0];
  endfunction

  // Monitor: samples on the falling edge.
  logic [3:0] sym_q[$];
  int   cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  int   lat_n = 0, lat_meas = -1;
  bit   lat_arm = 0, prev_stall = 0, prev_done = 0;
  logic [3:0] prev_sym = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      lat_arm    = 0;
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        acc_cyc  = cyc;
        lat_arm  = 1;
        lat_n    = 0;
        lat_meas = -1;
      end else if (lat_arm) begin
        lat_n++;
        if (sym_valid) begin
          lat_meas = lat_n;
          lat_arm  = 0;
        end
      end
      if (prev_stall) chk("stall_hold", sym_out, prev_sym);
      if (sym_valid)  chk("busy_in_ready", in_ready, 0);
      if (burst_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_in_ready", in_ready, 1);
        chk("done_pulse_width", prev_done, 0);
        chk("done_sym_valid", sym_valid, 0);
      end
      if (sym_valid && sym_ready) sym_q.push_back(sym_out);
      prev_stall = sym_valid && !sym_ready;
      prev_sym   = sym_out;
      prev_done  = burst_done;
    end
  end

  bit rnd_rdy = 0;
  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 sym_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Raise in_valid and return right after the accepting edge.
  task automatic accept(input logic [61:0] p, output bit ok);
    int a0, n;
    a0 = acc_cnt;
    n  = 0;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = p;
    while (acc_cnt == a0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    ok = (acc_cnt != a0);
    if (!ok) chk("accept_timeout", 1, 0);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int n;
    n = 0;
    while (done_cnt < target && n < 4000) begin
      @(posedge clk);
      n++;
    end
    ok = (done_cnt >= target);
    if (!ok) chk("done_timeout", 1, 0);
  endtask

  task automatic check_syms(input string tag, input int off, input logic [61:0] p);
    logic [127:0] exp_st, got_st;
    logic [3:0]   e;
    exp_st = model_stream(p);
    got_st = '0;
    for (int n = 0; n < 32; n++) begin
      e = {exp_st[4*n], exp_st[4*n+1], exp_st[4*n+2], exp_st[4*n+3]};
      chk($sformatf("%s_sym%0d", tag, n), sym_q[off+n], e);
      for (int b = 0; b < 4; b++) got_st[4*n+b] = sym_q[off+n][3-b];
    end
    chk({tag, "_loopback"}, decode(got_st), p);
  endtask

  task automatic run_burst(input string tag, input logic [61:0] p, input bit rr);
    bit ok;
    int d0;
    rnd_rdy = rr;
    sym_q.delete();
    d0 = done_cnt;
    accept(p, ok);
    if (!ok) return;
    wait_done(d0 + 1, ok);
    if (!ok) return;
    chk({tag, "_latency"}, lat_meas, 65);
    if (!rr) chk({tag, "_burst_len"}, done_cyc - acc_cyc, 97);
    chk({tag, "_handshakes"}, sym_q.size(), 32);
    if (sym_q.size() == 32) check_syms(tag, 0, p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_sym_valid"}, sym_valid, 0);
    chk({tag, "_sym_out"}, sym_out, 0);
    chk({tag, "_burst_done"}, burst_done, 0);
  endtask

  // Abort a burst after 'wait_cyc' edges, then verify silence.
  task automatic reset_abort(input string tag, input logic [61:0] p, input int wait_cyc);
    bit ok;
    rnd_rdy = 0;
    accept(p, ok);
    repeat (wait_cyc) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_vals(tag);
    @(posedge clk);
    #1 reset_n = 1'b1;
    sym_q.delete();
    repeat (80) @(posedge clk);
    chk({tag, "_no_partial"}, sym_q.size(), 0);
    #1 chk({tag, "_idle_after"}, in_ready, 1);
  endtask

  initial begin
    bit ok;
    int d0, a0, n;
    logic [61:0] pa, pb;
    logic [127:0] st1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    reset_n = 1'b1;

    // all-zero payload
    run_burst("zero", 62'h0, 0);

    // single impulse: known symbol pattern
    run_burst("impulse", 62'h1, 0);
    st1 = 128'h0;
    st1[0] = 1'b1; st1[16] = 1'b1; st1[32] = 1'b1; st1[64] = 1'b1; st1[80] = 1'b1;
    chk("impulse_stream_const", model_stream(62'h1), st1);
    if (sym_q.size() == 32) begin
      chk("impulse_s0", sym_q[0], 4'b1000);
      chk("impulse_s20", sym_q[20], 4'b1000);
      chk("impulse_s1", sym_q[1], 4'b0000);
    end

    // impulse with stalls
    run_burst("impulse_stall", 62'h1, 1);

    // random payloads, alternating ready behaviour
    for (int r = 0; r < 8; r++)
      run_burst($sformatf("rand%0d", r), 62'({$urandom(), $urandom()}), 1'(r));
    run_burst("ones", {62{1'b1}}, 1);

    // reset mid-ENCODE and mid-SEND, then a clean burst
    reset_abort("rst_enc", 62'({$urandom(), $urandom()}), 31);
    reset_abort("rst_send", 62'({$urandom(), $urandom()}), 74);
    run_burst("post_reset", 62'({$urandom(), $urandom()}), 1);

    // back-to-back with in_valid held high
    pa = 62'({$urandom(), $urandom()});
    pb = 62'({$urandom(), $urandom()});
    rnd_rdy = 1;
    sym_q.delete();
    d0 = done_cnt;
    a0 = acc_cnt;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = pa;
    n = 0;
    while (acc_cnt == a0 && n < 300) begin @(posedge clk); n++; end
    #1 in_data = pb;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 4000) begin @(posedge clk); n++; end
    #1 in_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - a0, 2);
    chk("b2b_accept_on_done", acc_cyc, done_cyc);
    wait_done(d0 + 2, ok);
    chk("b2b_handshakes", sym_q.size(), 64);
    if (ok && sym_q.size() == 64) begin
      check_syms("b2b_a", 0, pa);
      check_syms("b2b_b", 32, pb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
